// File: rtl/iic_byte_write_ctrl.sv
// iic_byte_write_ctrl
// Single-clock I2C master that performs one EEPROM byte write per request:
// START, control byte {DEV_ADDR,0}, word address, data byte (each followed
// by an ACK slot), then STOP. SCL is derived from clk by a quarter-period
// counter, so every bit occupies four quarters of QTR clk cycles.
// A NACK in any ACK slot aborts with a STOP and sets a sticky error flag.
//
// Ports:
//   clk      system clock, all logic on its rising edge
//   rst_n    synchronous active-low reset
//   start    write request pulse, accepted only while busy is low
//   wr_addr  EEPROM word address, latched on acceptance
//   wr_data  data byte, latched on acceptance
//   sda_i    sampled SDA pad level (only looked at in ACK slots)
//   scl      I2C clock level (1 = released/high)
//   sda_low  1 = pull SDA low, 0 = release
//   busy     transaction in progress
//   done     one-cycle pulse when a transaction ends (success or abort)
//   ack_err  sticky NACK flag, cleared by the next accepted start
module iic_byte_write_ctrl #(
  parameter int         QTR      = 125,
  parameter logic [6:0] DEV_ADDR = 7'b1010000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_i,
  output logic       scl,
  output logic       sda_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int            QW        = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QMAX      = QW'(QTR - 1);
  localparam logic [7:0]    CTRL_BYTE = {DEV_ADDR, 1'b0};

  typedef enum logic [3:0] {
    IDLE, STA, CTRL, ACK1, WADR, ACK2, WDAT, ACK3, STO
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [2:0]    bit_idx;
  logic [7:0]    addr_reg;
  logic [7:0]    data_reg;
  logic          nack;

  state_t        nxt_state;
  logic [2:0]    nxt_bit;
  logic [7:0]    cur_byte;
  logic [7:0]    nxt_byte;
  logic          cur_bitval;
  logic          nxt_bitval;

  function automatic logic is_ack(state_t s);
    return (s == ACK1) || (s == ACK2) || (s == ACK3);
  endfunction

  function automatic logic [7:0] sel_byte(state_t s, logic [7:0] a, logic [7:0] d);
    logic [7:0] b;
    case (s)
      CTRL:    b = CTRL_BYTE;
      WADR:    b = a;
      WDAT:    b = d;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Pin pattern {scl, sda_low} for a given state, quarter and data bit.
  // In bit and ACK states SCL is low for q0/q1 and high for q2/q3, so
  // phase[1] is exactly the SCL level; SDA only moves when q0 begins.
  function automatic logic [1:0] pins_f(state_t s, logic [1:0] q, logic b);
    logic [1:0] p;
    case (s)
      STA:              p = {1'b1, q[1]};
      CTRL, WADR, WDAT: p = {q[1], ~b};
      ACK1, ACK2, ACK3: p = {q[1], 1'b0};
      STO:              p = {q[1], (q != 2'd3)};
      default:          p = 2'b10;
    endcase
    return p;
  endfunction

  // Where the sequencer goes at the end of the current SCL period.
  // A NACK from any ACK slot short-cuts straight to STOP.
  always_comb begin
    nxt_state = state;
    nxt_bit   = 3'd7;
    case (state)
      STA:  nxt_state = CTRL;
      CTRL: begin
        nxt_state = (bit_idx == 3'd0) ? ACK1 : CTRL;
        nxt_bit   = (bit_idx == 3'd0) ? 3'd7 : bit_idx - 3'd1;
      end
      ACK1: nxt_state = nack ? STO : WADR;
      WADR: begin
        nxt_state = (bit_idx == 3'd0) ? ACK2 : WADR;
        nxt_bit   = (bit_idx == 3'd0) ? 3'd7 : bit_idx - 3'd1;
      end
      ACK2: nxt_state = nack ? STO : WDAT;
      WDAT: begin
        nxt_state = (bit_idx == 3'd0) ? ACK3 : WDAT;
        nxt_bit   = (bit_idx == 3'd0) ? 3'd7 : bit_idx - 3'd1;
      end
      ACK3:    nxt_state = STO;
      STO:     nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  assign cur_byte   = sel_byte(state, addr_reg, data_reg);
  assign nxt_byte   = sel_byte(nxt_state, addr_reg, data_reg);
  assign cur_bitval = cur_byte[bit_idx];
  assign nxt_bitval = nxt_byte[nxt_bit];

  // Sequencer: pins are registered and always set for the quarter that is
  // about to begin, so scl/sda_low change exactly on quarter boundaries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      qcnt     <= '0;
      phase    <= 2'd0;
      bit_idx  <= 3'd0;
      addr_reg <= 8'h00;
      data_reg <= 8'h00;
      nack     <= 1'b0;
      scl      <= 1'b1;
      sda_low  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state    <= STA;
          qcnt     <= '0;
          phase    <= 2'd0;
          bit_idx  <= 3'd7;
          addr_reg <= wr_addr;
          data_reg <= wr_data;
          nack     <= 1'b0;
          ack_err  <= 1'b0;
          busy     <= 1'b1;
          scl      <= 1'b1;
          sda_low  <= 1'b0;
        end
      end else if (qcnt != QMAX) begin
        qcnt <= qcnt + 1'b1;
      end else begin
        qcnt <= '0;
        if (phase != 2'd3) begin
          phase <= phase + 2'd1;
          {scl, sda_low} <= pins_f(state, phase + 2'd1, cur_bitval);
          // Slave answer is taken on the last cycle of q2, mid SCL-high.
          if (is_ack(state) && (phase == 2'd2)) begin
            nack <= sda_i;
          end
        end else begin
          phase   <= 2'd0;
          state   <= nxt_state;
          bit_idx <= nxt_bit;
          {scl, sda_low} <= pins_f(nxt_state, 2'd0, nxt_bitval);
          if (is_ack(state) && nack) begin
            ack_err <= 1'b1;
          end
          if (state == STO) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_iic_byte_write_ctrl.sv
// tb_iic_byte_write_ctrl
// Bench for iic_byte_write_ctrl. A fast instance (QTR=2) is driven with
// directed and random write requests; a bus monitor decodes SDA on SCL
// rising edges, plays the EEPROM slave in the ACK slots and counts START/
// STOP conditions. Expected bytes, busy length and error flag come from a
// transaction-level model (bytes sent, periods = 2 + 9*bytes). A slow
// instance (QTR=125) checks real-rate SCL period and busy length.
module tb_iic_byte_write_ctrl;

  localparam int         Q   = 2;
  localparam int         QS  = 125;
  localparam logic [6:0] DEV = 7'b1010000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       sda_i;
  logic       scl, sda_low, busy, done, ack_err;

  logic       start_s;
  logic       sda_i_s;
  logic       scl_s, sda_low_s, busy_s, done_s, ack_err_s;

  int n_compared = 0;
  int n_mismatched = 0;

  iic_byte_write_ctrl #(.QTR(Q), .DEV_ADDR(DEV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_addr(wr_addr),
    .wr_data(wr_data), .sda_i(sda_i), .scl(scl), .sda_low(sda_low),
    .busy(busy), .done(done), .ack_err(ack_err)
  );

  iic_byte_write_ctrl #(.QTR(QS), .DEV_ADDR(DEV)) dut_slow (
    .clk(clk), .rst_n(rst_n), .start(start_s), .wr_addr(8'h55),
    .wr_data(8'hC3), .sda_i(sda_i_s), .scl(scl_s), .sda_low(sda_low_s),
    .busy(busy_s), .done(done_s), .ack_err(ack_err_s)
  );

  always #5 clk = ~clk;

  // Monitor/slave state for the fast instance
  int         nack_slot = 0;
  int         busy_cycles = 0;
  int         done_count = 0;
  int         rises = 0;
  int         n_sta = 0;
  int         n_sto = 0;
  int         pos;
  logic [7:0] shift = 8'h00;
  logic [7:0] got_q[$];
  logic       err_at_done = 1'b0;
  logic       done_with_busy = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sl = 1'b0;
  logic       prev_busy = 1'b0;
  logic       drive_on = 1'b0;
  logic       drive_val = 1'b0;
  logic       release_pend = 1'b0;

  // Bus monitor: decodes bits on SCL rise, answers ACK slots from
  // nack_slot and feeds random noise on sda_i everywhere else.
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      busy_cycles    = 1;
      done_count     = 0;
      rises          = 0;
      n_sta          = 0;
      n_sto          = 0;
      got_q.delete();
      drive_on       = 1'b0;
      release_pend   = 1'b0;
      done_with_busy = 1'b0;
    end else if (busy) begin
      busy_cycles++;
    end
    if (done) begin
      done_count++;
      err_at_done = ack_err;
      if (busy) done_with_busy = 1'b1;
    end
    if (busy && prev_scl && scl && (sda_low != prev_sl)) begin
      if (sda_low) n_sta++;
      else n_sto++;
    end
    if (busy && !prev_scl && scl) begin
      pos = rises % 9;
      if (pos < 8) shift = {shift[6:0], ~sda_low};
      if (pos == 7) begin
        got_q.push_back(shift);
        drive_on  = 1'b1;
        drive_val = (nack_slot == (rises / 9) + 1);
      end
      if (pos == 8) release_pend = 1'b1;
      rises++;
    end
    if (prev_scl && !scl && release_pend) begin
      drive_on     = 1'b0;
      release_pend = 1'b0;
    end
    sda_i     = drive_on ? drive_val : 1'($urandom);
    prev_scl  = scl;
    prev_sl   = sda_low;
    prev_busy = busy;
  end

  // Monitor for the slow instance: busy length, SCL period, SDA edges
  // while SCL is high, done pulses.
  int   s_busy = 0;
  int   s_cyc = 0;
  int   s_rise = 0;
  int   s_t1 = 0;
  int   s_t2 = 0;
  int   s_edges = 0;
  int   s_done = 0;
  logic s_err = 1'b0;
  logic s_pscl = 1'b1;
  logic s_psl = 1'b0;
  logic s_pbusy = 1'b0;

  always @(negedge clk) begin
    s_cyc++;
    if (busy_s && !s_pbusy) begin
      s_busy  = 1;
      s_rise  = 0;
      s_edges = 0;
      s_done  = 0;
    end else if (busy_s) begin
      s_busy++;
    end
    if (busy_s && !s_pscl && scl_s) begin
      if (s_rise == 0) s_t1 = s_cyc;
      else if (s_rise == 1) s_t2 = s_cyc;
      s_rise++;
    end
    if (busy_s && s_pscl && scl_s && (sda_low_s != s_psl)) s_edges++;
    if (done_s) begin
      s_done++;
      s_err = ack_err_s;
    end
    s_pscl  = scl_s;
    s_psl   = sda_low_s;
    s_pbusy = busy_s;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One write transaction; nk = ACK slot (1..3) the slave NACKs, 0 = none.
  // With repulse, start is re-pulsed mid-transfer with different data.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d,
                               input int nk, input bit repulse);
    int         c;
    int         nb_exp;
    int         limit;
    logic [7:0] exp_bytes[3];
    nack_slot    = nk;
    nb_exp       = (nk == 0) ? 3 : nk;
    exp_bytes[0] = {DEV, 1'b0};
    exp_bytes[1] = a;
    exp_bytes[2] = d;
    limit        = 116 * Q + 20;
    wr_addr = a;
    wr_data = d;
    start   = 1'b1;
    step();
    start   = 1'b0;
    checkOutput("accept", 32'(busy), 32'd1);
    checkOutput("errclr", 32'(ack_err), 32'd0);
    c = 1;
    while (done_count == 0 && c < limit) begin
      start = repulse && (c == 10 || c == 100);
      if (start) begin
        wr_data = ~d;
        wr_addr = ~a;
      end
      step();
      c++;
    end
    start = 1'b0;
    if (done_count == 0) checkOutput("timeout", 32'd0, 32'd1);
    checkOutput("busy_len", 32'(busy_cycles), 32'((2 + 9 * nb_exp) * 4 * Q));
    checkOutput("done_cnt", 32'(done_count), 32'd1);
    checkOutput("done_busy", 32'(done_with_busy), 32'd0);
    checkOutput("ack_err", 32'(err_at_done), 32'(nk != 0));
    checkOutput("nbytes", 32'(got_q.size()), 32'(nb_exp));
    for (int i = 0; i < nb_exp && i < got_q.size(); i++) begin
      checkOutput($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_bytes[i]));
    end
    checkOutput("start_cond", 32'(n_sta), 32'd1);
    checkOutput("stop_cond", 32'(n_sto), 32'd1);
  endtask

  initial begin
    int lim;
    rst_n   = 1'b0;
    start   = 1'b0;
    start_s = 1'b0;
    sda_i_s = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    repeat (3) step();
    checkOutput("rst_scl", 32'(scl), 32'd1);
    checkOutput("rst_sda", 32'(sda_low), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(ack_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    $display("[TB] directed full write");
    applyStimulus(8'h3C, 8'hA5, 0, 1'b0);
    repeat (3) step();

    $display("[TB] NACK on control byte");
    applyStimulus(8'h12, 8'h34, 1, 1'b0);
    repeat (5) step();
    checkOutput("err_hold", 32'(ack_err), 32'd1);
    checkOutput("idle_scl", 32'(scl), 32'd1);

    $display("[TB] NACK on data then back-to-back write");
    applyStimulus(8'h81, 8'h7E, 3, 1'b0);
    applyStimulus(8'hF0, 8'h0F, 0, 1'b0);
    repeat (3) step();

    $display("[TB] start re-pulsed during transfer");
    applyStimulus(8'h5A, 8'hC6, 0, 1'b1);
    repeat (3) step();

    $display("[TB] reset mid-transfer");
    wr_addr = 8'h22;
    wr_data = 8'h99;
    start   = 1'b1;
    step();
    start   = 1'b0;
    repeat (49) step();
    rst_n = 1'b0;
    step();
    checkOutput("abort_scl", 32'(scl), 32'd1);
    checkOutput("abort_sda", 32'(sda_low), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (10) step();
    checkOutput("abort_nodone", 32'(done_count), 32'd0);
    applyStimulus(8'h66, 8'h18, 0, 1'b0);
    repeat (2) step();

    $display("[TB] random writes");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 3))) step();
    end

    $display("[TB] full write at QTR=125");
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    lim = 0;
    while (s_done == 0 && lim < 116 * QS + 50) begin
      step();
      lim++;
    end
    if (s_done == 0) checkOutput("slow_timeout", 32'd0, 32'd1);
    checkOutput("slow_busy", 32'(s_busy), 32'(116 * QS));
    checkOutput("slow_period", 32'(s_t2 - s_t1), 32'(4 * QS));
    checkOutput("slow_edges", 32'(s_edges), 32'd2);
    checkOutput("slow_done", 32'(s_done), 32'd1);
    checkOutput("slow_err", 32'(s_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
